// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor: one WIDTH/STAGES slice per cycle,
// valid/ready flow control per stage, flags produced alongside the final sum.
module pipelined_cla_addsub #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned BLOCK  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk_1,
  input  logic             i_rstn_1,
  input  logic             i_valid_1,
  output logic             o_ready_1,
  input  logic             i_sub_1,
  input  logic             i_cIn_1,
  input  logic [WIDTH-1:0] i_operandA_W,
  input  logic [WIDTH-1:0] i_operandB_W,
  output logic             o_valid_1,
  input  logic             i_ready_1,
  output logic [WIDTH-1:0] o_result_W,
  output logic             o_cOut_1,
  output logic             o_overflow_1,
  output logic             o_zero_1
);

  localparam int unsigned SLICE  = WIDTH / STAGES;
  localparam int unsigned GROUPS = SLICE / BLOCK;
  localparam int unsigned LAST   = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH / BLOCK || WIDTH % (STAGES * BLOCK) != 0) begin : g_param_check
    $error("pipelined_cla_addsub: WIDTH must be a multiple of STAGES*BLOCK, 1 <= STAGES <= WIDTH/BLOCK");
  end

  // Returns {carry out of slice, carry into slice MSB, slice sum}.
  // Carries inside a group are full lookahead terms; groups chain on their group carry.
  function automatic logic [SLICE+1:0] cla_slice(input logic [SLICE-1:0] a,
                                                 input logic [SLICE-1:0] b,
                                                 input logic             cin);
    logic [SLICE-1:0] p;
    logic [SLICE-1:0] g;
    logic [SLICE:0]   c;
    logic             gen;
    logic             prop;
    logic             term;
    int unsigned      base;
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    c[0] = cin;
    for (int unsigned grp = 0; grp < GROUPS; grp++) begin
      base = grp * BLOCK;
      for (int unsigned j = 0; j < BLOCK; j++) begin
        gen  = 1'b0;
        prop = 1'b1;
        for (int unsigned m = 0; m <= j; m++) begin
          term = g[base+m];
          for (int unsigned n = m + 1; n <= j; n++) term = term & p[base+n];
          gen  = gen | term;
          prop = prop & p[base+m];
        end
        c[base+j+1] = gen | (prop & c[base]);
      end
    end
    return {c[SLICE], c[SLICE-1], p ^ c[SLICE-1:0]};
  endfunction

  logic [STAGES-1:0] valid_q, valid_d;
  logic [STAGES-1:0] carry_q, carry_d;
  logic [WIDTH-1:0]  opa_q [STAGES];
  logic [WIDTH-1:0]  opa_d [STAGES];
  logic [WIDTH-1:0]  opb_q [STAGES];
  logic [WIDTH-1:0]  opb_d [STAGES];
  logic [WIDTH-1:0]  res_q [STAGES];
  logic [WIDTH-1:0]  res_d [STAGES];
  logic              ovf_q, ovf_d;
  logic              zero_q, zero_d;

  logic [STAGES:0]   stage_ready;
  logic [STAGES-1:0] src_valid;
  logic [STAGES-1:0] src_carry;
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_res [STAGES];
  logic [SLICE+1:0]  slice_w;

  always_comb begin
    stage_ready[STAGES] = i_ready_1;
    for (int unsigned i = 0; i < STAGES; i++) begin
      stage_ready[LAST-i] = ~valid_q[LAST-i] | stage_ready[LAST-i+1];
    end

    // Subtraction is folded in at entry: B inverted, carry-in forced high.
    src_valid[0] = i_valid_1;
    src_carry[0] = i_sub_1 | i_cIn_1;
    src_a[0]     = i_operandA_W;
    src_b[0]     = i_sub_1 ? ~i_operandB_W : i_operandB_W;
    src_res[0]   = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src_valid[k] = valid_q[k-1];
      src_carry[k] = carry_q[k-1];
      src_a[k]     = opa_q[k-1];
      src_b[k]     = opb_q[k-1];
      src_res[k]   = res_q[k-1];
    end

    valid_d = valid_q;
    carry_d = carry_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    slice_w = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (stage_ready[k]) begin
        slice_w    = cla_slice(src_a[k][k*SLICE +: SLICE], src_b[k][k*SLICE +: SLICE], src_carry[k]);
        valid_d[k] = src_valid[k];
        carry_d[k] = slice_w[SLICE+1];
        opa_d[k]   = src_a[k];
        opb_d[k]   = src_b[k];
        res_d[k]   = src_res[k];
        res_d[k][k*SLICE +: SLICE] = slice_w[SLICE-1:0];
        if (k == LAST) begin
          ovf_d  = src_valid[k] & (slice_w[SLICE+1] ^ slice_w[SLICE]);
          zero_d = src_valid[k] & (res_d[k] == '0);
        end
      end
    end
  end

  always_ff @(posedge i_clk_1 or negedge i_rstn_1) begin
    if (!i_rstn_1) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
    end
  end

  assign o_ready_1    = stage_ready[0];
  assign o_valid_1    = valid_q[LAST];
  assign o_result_W   = valid_q[LAST] ? res_q[LAST] : '0;
  assign o_cOut_1     = valid_q[LAST] & carry_q[LAST];
  assign o_overflow_1 = ovf_q;
  assign o_zero_1     = zero_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub: directed cases on a STAGES=2 instance,
// then concurrent random valid/ready traffic on STAGES = 1, 2, 4, 8 instances.
module tb_pipelined_cla_addsub;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_done = 0;
  logic rand_go = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Independent reference: (WIDTH+1)-bit sum, overflow from operand/result signs.
  function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic sub, input logic cin);
    logic [31:0] bb;
    logic [32:0] s;
    bb = sub ? ~b : b;
    s  = {1'b0, a} + {1'b0, bb} + {32'd0, sub | cin};
    return {s[31:0], s[32], (a[31] == bb[31]) && (s[31] != a[31]), s[31:0] == 32'd0};
  endfunction

  function automatic logic [31:0] rnd_op();
    case ($urandom_range(7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed instance (STAGES=2) ----------------
  logic        d_valid, d_o_ready, d_sub, d_cin, d_o_valid, d_rdy_in, d_cout, d_ovf, d_zero;
  logic [31:0] d_a, d_b, d_result;
  logic [34:0] d_exp [$];
  int          d_acc [$];
  int          d_nout = 0;
  logic        d_lat_chk = 1'b0;
  logic [31:0] held;
  logic [31:0] bp_a, bp_b;
  int          n_before;

  pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
    .i_clk_1(clk), .i_rstn_1(rst_n), .i_valid_1(d_valid), .o_ready_1(d_o_ready),
    .i_sub_1(d_sub), .i_cIn_1(d_cin), .i_operandA_W(d_a), .i_operandB_W(d_b),
    .o_valid_1(d_o_valid), .i_ready_1(d_rdy_in), .o_result_W(d_result),
    .o_cOut_1(d_cout), .o_overflow_1(d_ovf), .o_zero_1(d_zero));

  always @(negedge clk) begin
    #1;
    if (rst_n && d_o_valid && d_rdy_in) begin
      d_nout++;
      if (d_exp.size() == 0) check("dut_spurious", 64'd1, 64'd0);
      else begin
        check("dut_result", {d_result, d_cout, d_ovf, d_zero}, d_exp.pop_front());
        if (d_lat_chk) check("dut_latency", cyc - d_acc.pop_front(), 64'd2);
        else void'(d_acc.pop_front());
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic drive_beat(input logic [31:0] a, input logic [31:0] b,
                            input logic sub, input logic cin, input logic [34:0] exp);
    d_valid = 1'b1; d_a = a; d_b = b; d_sub = sub; d_cin = cin;
    for (int i = 0; i < 50; i++) begin
      #1;
      if (d_o_ready) begin
        d_exp.push_back(exp);
        d_acc.push_back(cyc);
        @(negedge clk);
        return;
      end
      @(negedge clk);
    end
    check("dut_accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 50 && d_exp.size() != 0; i++) @(negedge clk);
    check(tag, d_exp.size(), 64'd0);
  endtask

  // ---------------- random instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_rand
    localparam int unsigned S = 1 << gi;
    logic        v_in, rdy_out, sub, cin, v_out, rdy_in, co, ov, z;
    logic [31:0] a, b, r;
    logic [34:0] exp_q [$];
    int          sent;

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(4), .STAGES(S)) u_dut (
      .i_clk_1(clk), .i_rstn_1(rst_n), .i_valid_1(v_in), .o_ready_1(rdy_out),
      .i_sub_1(sub), .i_cIn_1(cin), .i_operandA_W(a), .i_operandB_W(b),
      .o_valid_1(v_out), .i_ready_1(rdy_in), .o_result_W(r),
      .o_cOut_1(co), .o_overflow_1(ov), .o_zero_1(z));

    initial begin
      v_in = 1'b0; rdy_in = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0; sent = 0;
      wait (rand_go);
      @(negedge clk);
      for (int c = 0; c < 60000 && (sent < 10000 || exp_q.size() != 0); c++) begin
        if (sent < 10000) begin
          v_in   = ($urandom_range(3) != 0);
          rdy_in = ($urandom_range(3) != 0);
          a = rnd_op(); b = rnd_op();
          sub = $urandom_range(1); cin = $urandom_range(1);
        end else begin
          v_in   = 1'b0;
          rdy_in = 1'b1;
        end
        #1;
        if (v_out && rdy_in) begin
          if (exp_q.size() == 0) check($sformatf("s%0d_spurious", S), 64'd1, 64'd0);
          else check($sformatf("s%0d_beat", S), {r, co, ov, z}, exp_q.pop_front());
        end else if (!v_out) begin
          check($sformatf("s%0d_idle_out", S), {r, co, ov, z}, 64'd0);
        end
        if (v_in && rdy_out) begin
          exp_q.push_back(model(a, b, sub, cin));
          sent++;
        end
        @(negedge clk);
      end
      v_in = 1'b0;
      check($sformatf("s%0d_sent", S), sent, 64'd10000);
      check($sformatf("s%0d_drained", S), exp_q.size(), 64'd0);
      n_done++;
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    d_valid = 1'b0; d_rdy_in = 1'b1; d_sub = 1'b0; d_cin = 1'b0; d_a = '0; d_b = '0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_outputs", {d_o_valid, d_result, d_cout, d_ovf, d_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", d_o_ready, 64'd1);
    @(negedge clk);

    d_lat_chk = 1'b1;
    drive_beat(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0001_0000, 1'b0, 1'b0, 1'b0});
    d_valid = 1'b0;
    wait_drain("drain_slice_carry");
    drive_beat(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, {32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0});
    d_valid = 1'b0;
    wait_drain("drain_sub_ovf");
    drive_beat(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    d_valid = 1'b0;
    wait_drain("drain_sub_equal");
    drive_beat(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1, {32'h0000_0000, 1'b1, 1'b0, 1'b1});
    d_valid = 1'b0;
    wait_drain("drain_wrap");
    d_lat_chk = 1'b0;

    // Backpressure: four beats offered while the sink refuses for three edges.
    d_rdy_in = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          bp_a = $urandom; bp_b = $urandom;
          drive_beat(bp_a, bp_b, i[0], 1'b0, model(bp_a, bp_b, i[0], 1'b0));
        end
        d_valid = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        #1;
        check("bp_ready_drop", d_o_ready, 64'd0);
        held = d_result;
        @(negedge clk);
        #1;
        check("bp_result_stable", d_result, held);
        check("bp_valid_hold", d_o_valid, 64'd1);
        @(negedge clk);
        d_rdy_in = 1'b1;
      end
    join
    wait_drain("drain_backpressure");

    // Reset with two beats held in the pipe.
    d_rdy_in = 1'b0;
    drive_beat(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0, model(32'h0000_1111, 32'h0000_2222, 1'b0, 1'b0));
    drive_beat(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0, model(32'h0000_3333, 32'h0000_4444, 1'b0, 1'b0));
    d_valid = 1'b0;
    #1;
    check("rst_mid_prevalid", d_o_valid, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", d_o_valid, 64'd0);
    d_exp.delete();
    d_acc.delete();
    n_before = d_nout;
    @(negedge clk);
    rst_n = 1'b1;
    d_rdy_in = 1'b1;
    repeat (8) @(negedge clk);
    check("rst_no_stale", d_nout, n_before);

    rand_go = 1'b1;
    for (int i = 0; i < 70000 && n_done < 4; i++) @(posedge clk);
    check("rand_finished", n_done, 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
